// File: rtl/act_skew_feeder.sv
// Activation skew feeder: streams N vectors from the activation SRAM and delays
// lane i by i cycles so the systolic array sees a diagonal wavefront.
module act_skew_feeder #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W-1:0]          num_rows,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [ARR_SIZE*DATA_W-1:0] mem_rd_data,
  output logic [ARR_SIZE*DATA_W-1:0] data_out,
  output logic [ARR_SIZE-1:0]        active_out,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  // Handshake: start is a one-cycle command with no ready; it is honoured only
  // while idle (busy=0). SRAM data is valid exactly one cycle after mem_rd_en.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // DRAIN lasts ARR_SIZE+1 cycles: one for stage 0, ARR_SIZE-1 for the deepest lane,
  // one more so the last lane's final beat is visible before FIN.
  localparam int DRN_W = $clog2(ARR_SIZE + 2);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(ARR_SIZE);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;

  logic                       rd_pend_q, rd_pend_d;
  logic [ARR_SIZE*DATA_W-1:0] stage0_q, stage0_d;
  logic                       stage0_vld_q, stage0_vld_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy        = 1'b0;
        rd_cnt_d    = '0;
        drain_cnt_d = '0;
        if (start) begin
          base_d  = base_addr;
          num_d   = num_rows;
          state_d = (num_rows == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + rd_cnt_q;
        rd_cnt_d  = rd_cnt_q + ADDR_W'(1);
        if (rd_cnt_q == num_q - ADDR_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;

  // Stage 0 captures the SRAM word; non-valid beats are zeroed here so every
  // downstream lane register carries zero fill for free.
  always_comb begin
    rd_pend_d    = mem_rd_en;
    stage0_vld_d = rd_pend_q;
    stage0_d     = rd_pend_q ? mem_rd_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      stage0_vld_q <= 1'b0;
      stage0_q     <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      stage0_vld_q <= stage0_vld_d;
      stage0_q     <= stage0_d;
    end
  end

  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign data_out[0 +: DATA_W] = stage0_q[0 +: DATA_W];
      assign active_out[0]         = stage0_vld_q;
    end else begin : g_skew
      // Each entry is {valid, data}; entry i-1 is the lane output.
      logic [DATA_W:0] pipe_q [i];
      logic [DATA_W:0] pipe_d [i];

      always_comb begin
        pipe_d[0] = {stage0_vld_q, stage0_q[i*DATA_W +: DATA_W]};
        for (int k = 1; k < i; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < i; k++) begin
            pipe_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < i; k++) begin
            pipe_q[k] <= pipe_d[k];
          end
        end
      end

      assign data_out[i*DATA_W +: DATA_W] = pipe_q[i-1][DATA_W-1:0];
      assign active_out[i]                = pipe_q[i-1][DATA_W];
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder: each scenario compares all outputs per cycle
// against a closed-form expectation of the run timeline plus hand-picked constants.
module tb_act_skew_feeder;
  localparam int ARR = 4;
  localparam int DW  = 8;
  localparam int AW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     num_rows;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [ARR*DW-1:0] mem_rd_data;
  logic [ARR*DW-1:0] data_out;
  logic [ARR-1:0]    active_out;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  typedef struct packed {
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [ARR*DW-1:0] data;
    logic [ARR-1:0]    active;
    logic              busy;
    logic              done;
  } out_t;

  logic [ARR*DW-1:0] mem [256];
  int checks = 0;
  int errors = 0;

  act_skew_feeder #(.ARR_SIZE(ARR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .data_out(data_out), .active_out(active_out),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / SRAM responder (garbage when not read, to expose missing zero fill)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_addr] : 32'hDEADBEEF;
  end

  function automatic out_t sample_outs();
    out_t o;
    o = {mem_rd_en, mem_addr, data_out, active_out, busy, done};
    return o;
  endfunction

  // Expected outputs in cycle cyc for a run whose start pulse is in cycle s.
  function automatic out_t model(int cyc, int s, int b, int n);
    out_t o;
    int t;
    int k;
    int done_cyc;
    logic [AW-1:0] a;
    o = '0;
    t = cyc - s;
    done_cyc = (n == 0) ? 1 : n + ARR + 2;
    if (t >= 1 && t <= n) begin
      o.rd_en = 1'b1;
      o.addr  = AW'(b + t - 1);
    end
    for (int i = 0; i < ARR; i++) begin
      k = t - 3 - i;
      if (k >= 0 && k < n) begin
        a = AW'(b + k);
        o.active[i] = 1'b1;
        o.data[i*DW +: DW] = mem[a][i*DW +: DW];
      end
    end
    o.busy = (t >= 1 && t <= done_cyc);
    o.done = (t == done_cyc);
    return o;
  endfunction

  // driver: change inputs just after the rising edge, return at the falling edge
  task automatic drive_cycle(input logic st, input logic [AW-1:0] b,
                             input logic [AW-1:0] n, input logic rst);
    @(posedge clk);
    #1;
    start     = st;
    base_addr = b;
    num_rows  = n;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t got;
    @(negedge clk);
    got = sample_outs();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
      got = sample_outs();
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got %h required 0", c, got);
      end
    end
  endtask

  task automatic test_basic();
    out_t got, exp;
    logic [DW-1:0] l0_tab [13];
    logic [DW-1:0] l3_tab [13];
    l0_tab = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    l3_tab = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 13; c++) begin
      drive_cycle(c == 0, 8'h10, 8'd3, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'h10, 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic cyc %0d: got %h required %h", c, got, exp);
      end
      checks++;
      if (data_out[0 +: DW] !== l0_tab[c] || data_out[3*DW +: DW] !== l3_tab[c]) begin
        errors++;
        $display("FAIL basic_lanes cyc %0d: got l0=%h l3=%h required l0=%h l3=%h",
                 c, data_out[0 +: DW], data_out[3*DW +: DW], l0_tab[c], l3_tab[c]);
      end
      checks++;
      if (done !== (c == 9)) begin
        errors++;
        $display("FAIL basic_done cyc %0d: got %b required %b", c, done, c == 9);
      end
    end
  endtask

  task automatic test_zero_rows();
    out_t got, exp;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(c == 0, 8'h20, 8'd0, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'h20, 0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL zero_rows cyc %0d: got %h required %h", c, got, exp);
      end
      checks++;
      if (busy !== (c == 1) || done !== (c == 1) || mem_rd_en !== 1'b0 || active_out !== '0) begin
        errors++;
        $display("FAIL zero_rows_flags cyc %0d: got busy=%b done=%b rd=%b act=%b required busy=%b done=%b rd=0 act=0",
                 c, busy, done, mem_rd_en, active_out, c == 1, c == 1);
      end
    end
  endtask

  task automatic test_addr_wrap();
    out_t got, exp;
    logic [AW-1:0] addr_tab [4];
    addr_tab = '{8'h00, 8'hFE, 8'hFF, 8'h00};
    for (int c = 0; c < 13; c++) begin
      drive_cycle(c == 0, 8'hFE, 8'd3, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'hFE, 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL addr_wrap cyc %0d: got %h required %h", c, got, exp);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (mem_addr !== addr_tab[c] || mem_rd_en !== 1'b1) begin
          errors++;
          $display("FAIL addr_wrap_seq cyc %0d: got addr=%h rd=%b required addr=%h rd=1",
                   c, mem_addr, mem_rd_en, addr_tab[c]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    out_t got, exp;
    logic st;
    for (int c = 0; c < 15; c++) begin
      st = (c == 0 || c == 2 || c == 9);
      drive_cycle(st, (c == 0) ? 8'h10 : 8'h40, (c == 0) ? 8'd3 : 8'd5, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'h10, 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ignored_start cyc %0d: got %h required %h", c, got, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    out_t got, exp;
    for (int c = 0; c < 14; c++) begin
      drive_cycle(c == 0, 8'h10, 8'd3, (c == 4 || c == 5));
      got = sample_outs();
      exp = (c < 4) ? model(c, 0, 8'h10, 3) : out_t'('0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset cyc %0d: got %h required %h", c, got, exp);
      end
    end
    for (int c = 0; c < 13; c++) begin
      drive_cycle(c == 0, 8'h10, 8'd3, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'h10, 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_reset_run cyc %0d: got %h required %h", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t got, exp;
    for (int c = 0; c < 23; c++) begin
      drive_cycle(c == 0 || c == 10, 8'h10, 8'd3, 1'b0);
      got = sample_outs();
      exp = model(c, 0, 8'h10, 3) | model(c, 10, 8'h10, 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h required %h", c, got, exp);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    for (int a = 0; a < 256; a++) begin
      mem[a] = {8'(a + 8'h30), 8'(a + 8'h20), 8'(a + 8'h10), 8'(a)};
    end
    mem[8'h10] = 32'h04030201;
    mem[8'h11] = 32'h08070605;
    mem[8'h12] = 32'h0C0B0A09;

    test_reset();
    test_basic();
    test_zero_rows();
    test_addr_wrap();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
